instruction_fetch_unit: RTL and testbench
=========================================

Name: instruction_fetch_unit

Overview:
- Initiator side of the instruction memory read interface: holds the program counter and drives a byte address into the combinational instruction memory.
- Registers the returned 32-bit word into a valid/ready output stage that feeds decode.
- Supports branch/jump redirect with pipeline flush, and flags misaligned redirect targets.
- Sits between instruction_memory and the RISC-V decode stage.

Parameters:
- DATA_WIDTH, 32, instruction word width; must match instruction_memory.
- ADDR_WIDTH, 4, byte-address width; must match instruction_memory; minimum 3.
- RESET_PC, 0, byte address fetched first after reset; must be 4-byte aligned.

Ports:
- clk  input  1  system clock, rising-edge.
- rst_n  input  1  asynchronous active-low reset.
- imem_address  output  ADDR_WIDTH  byte address to instruction_memory; always equals the pc register.
- imem_instruction  input  DATA_WIDTH  combinational read data from instruction_memory.
- redirect_valid  input  1  load a new pc this cycle (branch/jump).
- redirect_pc  input  ADDR_WIDTH  redirect target byte address.
- inst_valid  output  1  inst/inst_pc hold a fetched instruction.
- inst_ready  input  1  decode accepts inst this cycle.
- inst  output  DATA_WIDTH  fetched instruction word.
- inst_pc  output  ADDR_WIDTH  byte address inst was fetched from.
- misalign_fault  output  1  sticky flag: last redirect target was not word-aligned.

Behaviour:
- Reset: one clock; asynchronous, active-low. While rst_n=0: pc=RESET_PC, inst_valid=0, inst=0, inst_pc=0, misalign_fault=0, state=FETCH. Reset asserted mid-operation clears all of these immediately; no handshake completes on that edge.
- imem_address is combinational from pc only; memory read data is sampled in the same cycle.
- States:
  - FETCH: normal operation.
  - FAULT: entered on a misaligned redirect; no fetching.
- Load condition: load = (state==FETCH) && !redirect_valid && (!inst_valid || inst_ready).
- On a load at the rising edge:
  - inst <= imem_instruction; inst_pc <= pc; inst_valid <= 1.
  - pc <= pc + 4, wrapping modulo 2^ADDR_WIDTH (ADDR_WIDTH=4: 12 -> 0).
- Throughput and latency:
  - Full rate: one instruction per cycle while inst_ready=1.
  - Latency: pc presented -> inst_valid high one edge later.
  - First inst_valid appears on the first clock edge after rst_n deasserts.
- Backpressure: inst_valid=1 and inst_ready=0 -> inst, inst_pc, inst_valid and pc all hold. Output must not change while valid and not accepted.
- Handshake completes when inst_valid && inst_ready at a rising edge.
- Redirect (highest priority, either state):
  - A handshake present in the same cycle still counts as completed.
  - inst_valid <= 0 (flush); pc <= redirect_pc.
  - If redirect_pc[1:0]==0: misalign_fault <= 0, state <= FETCH; the first fetch from the target is registered on the following edge.
  - If redirect_pc[1:0]!=0: misalign_fault <= 1, state <= FAULT.
- FAULT:
  - inst_valid stays 0; pc holds; imem_address still equals pc.
  - Exits only on an aligned redirect or reset.
  - A misaligned redirect while in FAULT updates pc and stays in FAULT.
- Back-to-back redirects: each flushes; only the last target is fetched.
- inst_ready while inst_valid=0 is ignored.
- pc[1:0] is always 0 in FETCH.

Test Plan:
- Memory preloaded with little-endian bytes 0x01..0x10. Release reset, inst_ready=1 -> inst 04030201, 08070605, 0c0b0a09, 100f0e0d on four consecutive cycles with inst_pc 0, 4, 8, 12; the 5th is 04030201 at inst_pc 0 (wrap).
- Backpressure: hold inst_ready=0 for 3 cycles after the first valid -> inst stays 04030201, inst_pc 0, imem_address stays 4. Raise inst_ready -> 08070605 on the next edge.
- Redirect to 8 while inst_valid=1 carries inst_pc 0 -> inst_valid=0 next cycle, then 0c0b0a09 at inst_pc 8, then 100f0e0d.
- Misaligned redirect to 6 -> misalign_fault=1, inst_valid stays 0 for 5 cycles. Then redirect to 4 -> fault clears, 08070605 delivered.
- Redirect and handshake in the same cycle -> handshake counted once, no duplicate instruction, next valid is from the target.
- Assert rst_n=0 asynchronously mid-stream (between edges) -> inst_valid, misalign_fault and imem_address go to 0 immediately. After release, the sequence restarts at 04030201.

Source files
------------

// File: rtl/instruction_fetch_unit_if.sv
// Fetch-side bus bundle: instruction memory read port, redirect input,
// valid/ready instruction output toward decode, and the misalign flag.
//   master : instruction_fetch_unit (drives address, instruction stage, fault)
//   slave  : memory/decode/branch environment
interface instruction_fetch_unit_if #(
  parameter int unsigned DATA_WIDTH = 32,
  parameter int unsigned ADDR_WIDTH = 4
);
  logic [ADDR_WIDTH-1:0] imem_address;
  logic [DATA_WIDTH-1:0] imem_instruction;
  logic                  redirect_valid;
  logic [ADDR_WIDTH-1:0] redirect_pc;
  logic                  inst_valid;
  logic                  inst_ready;
  logic [DATA_WIDTH-1:0] inst;
  logic [ADDR_WIDTH-1:0] inst_pc;
  logic                  misalign_fault;

  modport master (
    output imem_address, inst_valid, inst, inst_pc, misalign_fault,
    input  imem_instruction, redirect_valid, redirect_pc, inst_ready
  );

  modport slave (
    input  imem_address, inst_valid, inst, inst_pc, misalign_fault,
    output imem_instruction, redirect_valid, redirect_pc, inst_ready
  );
endinterface

// File: rtl/instruction_fetch_unit.sv
// Instruction fetch unit: holds the pc, reads a combinational instruction
// memory, and registers each word into a valid/ready stage feeding decode.
// Redirects flush the stage; a misaligned target parks the unit in FAULT.
// Ports:
//   clk   - rising-edge clock
//   rst_n - asynchronous active-low reset
//   bus   - instruction_fetch_unit_if.master (memory, redirect, decode, fault)
module instruction_fetch_unit #(
  parameter int unsigned DATA_WIDTH = 32,
  parameter int unsigned ADDR_WIDTH = 4,
  parameter int unsigned RESET_PC   = 0
) (
  input  logic                    clk,
  input  logic                    rst_n,
  instruction_fetch_unit_if.master bus
);

  localparam int unsigned PC_STEP = 4;

  typedef enum logic [0:0] {
    FETCH = 1'b0,
    FAULT = 1'b1
  } state_t;

  state_t                state_q, state_d;
  logic [ADDR_WIDTH-1:0] pc_q, pc_d;
  logic                  valid_q, valid_d;
  logic [DATA_WIDTH-1:0] inst_q, inst_d;
  logic [ADDR_WIDTH-1:0] inst_pc_q, inst_pc_d;
  logic                  fault_q, fault_d;
  logic                  load_c;
  logic                  target_misaligned_c;

  assign target_misaligned_c = (bus.redirect_pc[1:0] != 2'b00);

  // State register
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q <= FETCH;
    end else begin
      state_q <= state_d;
    end
  end

  // Next state: only a redirect moves between FETCH and FAULT
  always_comb begin
    state_d = state_q;
    if (bus.redirect_valid) begin
      state_d = target_misaligned_c ? FAULT : FETCH;
    end
  end

  // Next values of pc and output stage; redirect outranks a load
  always_comb begin
    load_c    = 1'b0;
    pc_d      = pc_q;
    valid_d   = valid_q;
    inst_d    = inst_q;
    inst_pc_d = inst_pc_q;
    fault_d   = fault_q;
    if (bus.redirect_valid) begin
      valid_d = 1'b0;
      pc_d    = bus.redirect_pc;
      fault_d = target_misaligned_c;
    end else if ((state_q == FETCH) && (!valid_q || bus.inst_ready)) begin
      load_c    = 1'b1;
      inst_d    = bus.imem_instruction;
      inst_pc_d = pc_q;
      valid_d   = 1'b1;
      pc_d      = pc_q + ADDR_WIDTH'(PC_STEP);
    end
  end

  // Datapath registers
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      pc_q      <= ADDR_WIDTH'(RESET_PC);
      valid_q   <= 1'b0;
      inst_q    <= '0;
      inst_pc_q <= '0;
      fault_q   <= 1'b0;
    end else begin
      pc_q      <= pc_d;
      valid_q   <= valid_d;
      inst_q    <= inst_d;
      inst_pc_q <= inst_pc_d;
      fault_q   <= fault_d;
    end
  end

  assign bus.imem_address   = pc_q;
  assign bus.inst_valid     = valid_q;
  assign bus.inst           = inst_q;
  assign bus.inst_pc        = inst_pc_q;
  assign bus.misalign_fault = fault_q;

endmodule

// File: tb/tb_instruction_fetch_unit.sv
// Bench for instruction_fetch_unit: directed walk through fetch, backpressure,
// redirect and fault cases, then random traffic against a reference model.
module tb_instruction_fetch_unit;

  localparam int unsigned DW = 32;
  localparam int unsigned AW = 4;

  logic clk = 1'b0;
  logic rst_n;
  always #5 clk = ~clk;

  instruction_fetch_unit_if #(.DATA_WIDTH(DW), .ADDR_WIDTH(AW)) bus ();

  instruction_fetch_unit #(.DATA_WIDTH(DW), .ADDR_WIDTH(AW), .RESET_PC(0)) dut (
    .clk   (clk),
    .rst_n (rst_n),
    .bus   (bus)
  );

  // Byte memory 0x01..0x10, read little-endian with address wrap
  logic [7:0] mem [16];
  always_comb begin
    bus.imem_instruction = {mem[bus.imem_address + AW'(3)], mem[bus.imem_address + AW'(2)],
                            mem[bus.imem_address + AW'(1)], mem[bus.imem_address]};
  end

  int n_checks = 0;
  int n_fail   = 0;

  // Reference model: fetch stream as plain arithmetic on the byte pattern
  logic [AW-1:0] m_pc;
  logic          m_valid;
  logic [DW-1:0] m_inst;
  logic [AW-1:0] m_inst_pc;
  logic          m_fault;
  logic          m_fetching;

  function automatic logic [DW-1:0] word_at(input int unsigned a);
    logic [DW-1:0] w;
    w = '0;
    for (int b = 0; b < 4; b++) begin
      w[b*8 +: 8] = 8'(((a + b) % 16) + 1);
    end
    return w;
  endfunction

  task automatic model_reset();
    m_pc = '0; m_valid = 1'b0; m_inst = '0; m_inst_pc = '0;
    m_fault = 1'b0; m_fetching = 1'b1;
  endtask

  task automatic model_edge();
    if (bus.redirect_valid) begin
      m_valid = 1'b0;
      m_pc    = bus.redirect_pc;
      m_fault = (bus.redirect_pc % 4) != 0;
      m_fetching = !m_fault;
    end else if (m_fetching && (!m_valid || bus.inst_ready)) begin
      m_inst    = word_at(int'(m_pc));
      m_inst_pc = m_pc;
      m_valid   = 1'b1;
      m_pc      = AW'((int'(m_pc) + 4) % 16);
    end
  endtask

  task automatic check(input string tag, input logic [DW-1:0] obs, input logic [DW-1:0] exp);
    n_checks++;
    assert (obs === exp) else begin
      n_fail++;
      $error("FAIL %s: observed %h expected %h", tag, obs, exp);
    end
  endtask

  task automatic compare_model();
    check("model_valid", DW'(bus.inst_valid), DW'(m_valid));
    check("model_addr", DW'(bus.imem_address), DW'(m_pc));
    check("model_fault", DW'(bus.misalign_fault), DW'(m_fault));
    if (m_valid) begin
      check("model_inst", bus.inst, m_inst);
      check("model_inst_pc", DW'(bus.inst_pc), DW'(m_inst_pc));
    end
  endtask

  task automatic tick();
    @(posedge clk);
    model_edge();
    #1;
    compare_model();
  endtask

  task automatic drive(input logic rv, input logic [AW-1:0] rpc, input logic rdy);
    bus.redirect_valid = rv;
    bus.redirect_pc    = rpc;
    bus.inst_ready     = rdy;
  endtask

  logic [DW-1:0] exp_tab [4];

  initial begin
    for (int i = 0; i < 16; i++) mem[i] = 8'(i + 1);
    exp_tab[0] = 32'h04030201; exp_tab[1] = 32'h08070605;
    exp_tab[2] = 32'h0c0b0a09; exp_tab[3] = 32'h100f0e0d;

    // Reset values
    rst_n = 1'b0;
    drive(1'b0, '0, 1'b1);
    model_reset();
    #12;
    check("rst_valid", DW'(bus.inst_valid), '0);
    check("rst_inst", bus.inst, '0);
    check("rst_inst_pc", DW'(bus.inst_pc), '0);
    check("rst_fault", DW'(bus.misalign_fault), '0);
    check("rst_addr", DW'(bus.imem_address), '0);
    rst_n = 1'b1;

    // Full-rate stream with wrap on the fifth word
    for (int i = 0; i < 5; i++) begin
      tick();
      check("stream_valid", DW'(bus.inst_valid), 32'd1);
      check("stream_inst", bus.inst, exp_tab[i % 4]);
      check("stream_pc", DW'(bus.inst_pc), DW'((i * 4) % 16));
    end

    // Backpressure holds everything
    drive(1'b0, '0, 1'b0);
    for (int i = 0; i < 3; i++) begin
      tick();
      check("bp_inst", bus.inst, 32'h04030201);
      check("bp_pc", DW'(bus.inst_pc), '0);
      check("bp_addr", DW'(bus.imem_address), 32'd4);
    end
    drive(1'b0, '0, 1'b1);
    tick();
    check("bp_release", bus.inst, 32'h08070605);

    // Advance until inst_pc 0 is presented, then redirect to 8 while held
    for (int i = 0; i < 3; i++) tick();
    check("pre_redir_pc", DW'(bus.inst_pc), '0);
    drive(1'b1, AW'(8), 1'b0);
    tick();
    check("redir_flush", DW'(bus.inst_valid), '0);
    drive(1'b0, '0, 1'b1);
    tick();
    check("redir_inst", bus.inst, 32'h0c0b0a09);
    check("redir_pc", DW'(bus.inst_pc), 32'd8);
    tick();
    check("redir_next", bus.inst, 32'h100f0e0d);

    // Misaligned redirect parks in FAULT
    drive(1'b1, AW'(6), 1'b1);
    tick();
    check("mis_fault", DW'(bus.misalign_fault), 32'd1);
    drive(1'b0, '0, 1'b1);
    for (int i = 0; i < 5; i++) begin
      tick();
      check("fault_novalid", DW'(bus.inst_valid), '0);
      check("fault_addr", DW'(bus.imem_address), 32'd6);
    end
    drive(1'b1, AW'(4), 1'b1);
    tick();
    check("fault_clear", DW'(bus.misalign_fault), '0);
    drive(1'b0, '0, 1'b1);
    tick();
    check("fault_exit_inst", bus.inst, 32'h08070605);
    check("fault_exit_pc", DW'(bus.inst_pc), 32'd4);

    // Redirect together with an accepted handshake
    drive(1'b1, AW'(12), 1'b1);
    tick();
    check("hs_redir_flush", DW'(bus.inst_valid), '0);
    drive(1'b0, '0, 1'b1);
    tick();
    check("hs_redir_inst", bus.inst, 32'h100f0e0d);
    check("hs_redir_pc", DW'(bus.inst_pc), 32'd12);

    // Random traffic against the model
    for (int i = 0; i < 400; i++) begin
      drive(($urandom_range(0, 9) == 0), AW'($urandom_range(0, 15)), 1'($urandom));
      tick();
    end

    // Asynchronous reset between edges
    drive(1'b1, AW'(8), 1'b1);
    tick();
    drive(1'b0, '0, 1'b1);
    tick();
    tick();
    @(posedge clk);
    model_edge();
    #3;
    rst_n = 1'b0;
    model_reset();
    #1;
    check("arst_valid", DW'(bus.inst_valid), '0);
    check("arst_fault", DW'(bus.misalign_fault), '0);
    check("arst_addr", DW'(bus.imem_address), '0);
    @(negedge clk);
    rst_n = 1'b1;
    tick();
    check("arst_restart_inst", bus.inst, 32'h04030201);
    check("arst_restart_pc", DW'(bus.inst_pc), '0);
    tick();
    check("arst_second", bus.inst, 32'h08070605);

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
